// File: rtl/windower_k.sv
// Streaming 1-D windower: each output beat carries the T+K-1 samples that cover
// T consecutive K-wide windows, with zero or replicate padding at image edges.
module windower_k #(
    parameter int NO_CH         = 2,
    parameter int LOG2_IMG_SIZE = 10,
    parameter int THROUGHPUT    = 1,
    parameter int KERNEL        = 3,
    parameter int PAD_MODE      = 0
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      vld_in,
    input  logic [THROUGHPUT-1:0][NO_CH-1:0]          data_in,
    output logic                                      vld_out,
    output logic [THROUGHPUT+KERNEL-2:0][NO_CH-1:0]   data_out,
    output logic                                      sof_out,
    output logic                                      eof_out,
    output logic [1:0]                                dbg_state_o
);

    localparam int T  = THROUGHPUT;
    localparam int P  = (KERNEL - 1) / 2;
    localparam int W  = T + 2 * P;
    localparam int CW = (LOG2_IMG_SIZE > 0) ? LOG2_IMG_SIZE : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'((1 << LOG2_IMG_SIZE) - 1);
    localparam bit SINGLE = (LOG2_IMG_SIZE == 0);

    // Valid-only stream: a beat is taken on every edge where vld_in is high; no ready exists.
    typedef enum logic [1:0] {IDLE, PRIME, RUN, FLUSH} state_t;

    state_t                      state_q, state_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [T-1:0][NO_CH-1:0]     cur_q, cur_d;
    logic [P-1:0][NO_CH-1:0]     prev_q, prev_d;
    logic                        vld_q, vld_d;
    logic                        sof_q, sof_d;
    logic                        eof_q, eof_d;
    logic [W-1:0][NO_CH-1:0]     data_q, data_d;

    logic                        last_beat;
    logic [CW-1:0]               cnt_inc;
    logic                        left_edge;
    logic                        right_edge;
    logic [NO_CH-1:0]            lpad;
    logic [NO_CH-1:0]            rpad;
    logic [W-1:0][NO_CH-1:0]     win;

    always_comb begin
        last_beat  = (cnt_q == LAST_BEAT);
        cnt_inc    = last_beat ? '0 : cnt_q + CW'(1);
        // In FLUSH of a one-beat image the stored beat is also the first one.
        left_edge  = (state_q == PRIME) || ((state_q == FLUSH) && SINGLE);
        right_edge = (state_q == FLUSH);
        lpad       = (PAD_MODE == 1) ? cur_q[0]   : '0;
        rpad       = (PAD_MODE == 1) ? cur_q[T-1] : '0;
        win        = '0;
        for (int i = 0; i < P; i++) begin
            win[i]         = left_edge  ? lpad : prev_q[i];
            win[P + T + i] = right_edge ? rpad : data_in[i];
        end
        for (int i = 0; i < T; i++) begin
            win[P + i] = cur_q[i];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cur_d   = cur_q;
        prev_d  = prev_q;
        vld_d   = 1'b0;
        sof_d   = 1'b0;
        eof_d   = 1'b0;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (vld_in) begin
                    cur_d   = data_in;
                    cnt_d   = cnt_inc;
                    state_d = SINGLE ? FLUSH : PRIME;
                end
            end
            PRIME, RUN: begin
                if (vld_in) begin
                    vld_d  = 1'b1;
                    sof_d  = (state_q == PRIME);
                    data_d = win;
                    for (int i = 0; i < P; i++) begin
                        prev_d[i] = cur_q[T - P + i];
                    end
                    cur_d   = data_in;
                    cnt_d   = cnt_inc;
                    state_d = last_beat ? FLUSH : RUN;
                end
            end
            FLUSH: begin
                vld_d  = 1'b1;
                eof_d  = 1'b1;
                sof_d  = SINGLE;
                data_d = win;
                if (vld_in) begin
                    cur_d   = data_in;
                    cnt_d   = cnt_inc;
                    state_d = SINGLE ? FLUSH : PRIME;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cur_q   <= '0;
            prev_q  <= '0;
            vld_q   <= 1'b0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cur_q   <= cur_d;
            prev_q  <= prev_d;
            vld_q   <= vld_d;
            sof_q   <= sof_d;
            eof_q   <= eof_d;
            data_q  <= data_d;
        end
    end

    assign vld_out     = vld_q;
    assign sof_out     = sof_q;
    assign eof_out     = eof_q;
    assign data_out    = data_q;
    assign dbg_state_o = state_q;

endmodule
